// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce: streaming FP32/FP64 min/max reduction with sticky
// invalid (sNaN) and all-NaN flags, valid/ready on both sides.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for the first element of a vector
// S_ACCUM | accumulating min/max/count over the remaining elements
// S_DONE  | result presented on out_*, held until out_ready
module fp_minmax_reduce #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_data,
  input  logic               in_last,
  input  logic               is_double_precision,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_min,
  output logic [63:0]        out_max,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_invalid,
  output logic               out_all_nan
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [63:0] QNAN_SP = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] QNAN_DP = 64'h7FF8_0000_0000_0000;

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 dp_q, dp_d;
  logic [63:0]          min_q, min_d;
  logic [63:0]          max_q, max_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 invalid_q, invalid_d;
  logic                 has_num_q, has_num_d;
  logic                 all_nan_q, all_nan_d;

  logic                 accept;
  logic                 first_el;
  logic                 dp_eff;
  logic [63:0]          op;
  logic                 op_nan;
  logic                 op_snan;

  // NaN: exponent all ones with a nonzero mantissa.
  function automatic logic is_nan_f(input logic [63:0] v, input logic dp);
    if (dp) return (&v[62:52]) && (|v[51:0]);
    return (&v[30:23]) && (|v[22:0]);
  endfunction

  // Signaling NaN: quiet bit (mantissa MSB) clear.
  function automatic logic is_snan_f(input logic [63:0] v, input logic dp);
    return is_nan_f(v, dp) && !(dp ? v[51] : v[22]);
  endfunction

  // Total order on non-NaN values: sign first, then raw exponent/mantissa
  // magnitude, with the magnitude order inverted for negatives.
  function automatic logic lt_f(input logic [63:0] a, input logic [63:0] b,
                                input logic dp);
    logic        sa, sb;
    logic [62:0] ma, mb;
    sa = dp ? a[63] : a[31];
    sb = dp ? b[63] : b[31];
    ma = dp ? a[62:0] : {32'b0, a[30:0]};
    mb = dp ? b[62:0] : {32'b0, b[30:0]};
    if (sa != sb) return sa;
    if (sa) return ma > mb;
    return ma < mb;
  endfunction

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_count   = count_q;
  assign out_invalid = invalid_q;
  assign out_all_nan = all_nan_q;

  // Next-state: element classification, min/max update and handshake sequencing.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dp_d        = dp_q;
    min_d       = min_q;
    max_d       = max_q;
    count_d     = count_q;
    invalid_d   = invalid_q;
    has_num_d   = has_num_q;
    all_nan_d   = all_nan_q;

    accept   = in_valid && in_ready_q;
    first_el = (state_q == S_IDLE);
    dp_eff   = first_el ? is_double_precision : dp_q;
    op       = dp_eff ? in_data : {32'b0, in_data[31:0]};
    op_nan   = is_nan_f(op, dp_eff);
    op_snan  = is_snan_f(op, dp_eff);

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          dp_d      = dp_eff;
          invalid_d = (first_el ? 1'b0 : invalid_q) | op_snan;
          has_num_d = (first_el ? 1'b0 : has_num_q) | !op_nan;

          if (first_el) begin
            count_d = COUNT_W'(1);
          end else if (!(&count_q)) begin
            count_d = count_q + COUNT_W'(1);
          end

          if (first_el) begin
            min_d = op;
            max_d = op;
          end else if (!op_nan) begin
            if (!has_num_q) begin
              // Only NaNs so far: the first number seeds both extremes.
              min_d = op;
              max_d = op;
            end else begin
              if (lt_f(op, min_q, dp_q)) min_d = op;
              if (lt_f(max_q, op, dp_q)) max_d = op;
            end
          end

          if (in_last) begin
            state_d     = S_DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            all_nan_d   = !has_num_d;
            if (!has_num_d) begin
              min_d = dp_eff ? QNAN_DP : QNAN_SP;
              max_d = dp_eff ? QNAN_DP : QNAN_SP;
            end
          end else begin
            state_d = S_ACCUM;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          invalid_d   = 1'b0;
          has_num_d   = 1'b0;
          count_d     = '0;
          all_nan_d   = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any partial vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dp_q        <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      count_q     <= '0;
      invalid_q   <= 1'b0;
      has_num_q   <= 1'b0;
      all_nan_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dp_q        <= dp_d;
      min_q       <= min_d;
      max_q       <= max_d;
      count_q     <= count_d;
      invalid_q   <= invalid_d;
      has_num_q   <= has_num_d;
      all_nan_q   <= all_nan_d;
    end
  end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Bench for fp_minmax_reduce: directed vectors plus random vectors checked
// against an ordering model built on signed integer keys.
module tb_fp_minmax_reduce;

  localparam int CW = 4;
  localparam logic [CW-1:0] SAT = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          is_double_precision = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_min;
  logic [63:0]   out_max;
  logic [CW-1:0] out_count;
  logic          out_invalid;
  logic          out_all_nan;

  int checks = 0;
  int errors = 0;
  logic [63:0] vec[$];

  fp_minmax_reduce #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .is_double_precision(is_double_precision),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_count(out_count),
    .out_invalid(out_invalid), .out_all_nan(out_all_nan)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Map a non-NaN value to a signed integer whose natural order is the FP order.
  function automatic logic signed [64:0] key(input logic [63:0] v, input bit dp);
    logic [62:0] mag;
    bit s;
    s   = dp ? v[63] : v[31];
    mag = dp ? v[62:0] : {32'b0, v[30:0]};
    if (s) return -$signed({2'b00, mag}) - 65'sd1;
    return $signed({2'b00, mag});
  endfunction

  task automatic model(input bit dp, output logic [63:0] emin, output logic [63:0] emax,
                       output logic [CW-1:0] ecnt, output logic einv, output logic eall);
    logic [63:0] v;
    logic signed [64:0] k, kmin, kmax;
    bit have, nan, quiet;
    have = 0; einv = 0; kmin = '0; kmax = '0; emin = '0; emax = '0;
    foreach (vec[i]) begin
      v = dp ? vec[i] : {32'h0, vec[i][31:0]};
      if (dp) begin
        nan = (v[62:52] == 11'h7FF) && (v[51:0] != 52'h0); quiet = v[51];
      end else begin
        nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'h0); quiet = v[22];
      end
      if (nan) begin
        if (!quiet) einv = 1;
      end else begin
        k = key(v, dp);
        if (!have || k < kmin) begin kmin = k; emin = v; end
        if (!have || k > kmax) begin kmax = k; emax = v; end
        have = 1;
      end
    end
    eall = !have;
    if (!have) begin
      emin = dp ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
      emax = emin;
    end
    ecnt = (vec.size() > int'(SAT)) ? SAT : CW'(vec.size());
  endtask

  function automatic logic [63:0] rand_fp(input bit dp);
    int unsigned c;
    bit s;
    logic [63:0] r;
    logic [10:0] e64;
    logic [51:0] m64;
    logic [7:0]  e32;
    logic [22:0] m32;
    c = $urandom_range(0, 9);
    s = 1'($urandom_range(0, 1));
    r = {$urandom, $urandom};
    e64 = r[62:52]; m64 = r[51:0];
    e32 = r[30:23]; m32 = r[22:0];
    case (c)
      0: begin e64 = '0; m64 = '0; e32 = '0; m32 = '0; end
      1: begin e64 = '1; m64 = '0; e32 = '1; m32 = '0; end
      2: begin e64 = '1; m64[51] = 1'b1; e32 = '1; m32[22] = 1'b1; end
      3: begin
        e64 = '1; m64[51] = 1'b0; if (m64 == 52'h0) m64[0] = 1'b1;
        e32 = '1; m32[22] = 1'b0; if (m32 == 23'h0) m32[0] = 1'b1;
      end
      4: begin e64 = '0; e32 = '0; end
      5: begin e64 = 11'h3FF; m64 = '0; e32 = 8'h7F; m32 = '0; end
      default: ;
    endcase
    if (dp) return {s, e64, m64};
    return {r[63:32], s, e32, m32};
  endfunction

  task automatic send(input logic [63:0] d, input bit last, input bit dp);
    int n;
    bit done;
    n = 0; done = 0;
    in_valid = 1; in_data = d; in_last = last; is_double_precision = dp;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1;
      end else begin
        n++;
        if (n > 30) begin
          checks++; errors++;
          $error("FAIL send_timeout: in_ready observed 0 expected 1");
          done = 1;
        end
      end
    end
    in_valid = 0; in_last = 0; in_data = {$urandom, $urandom};
  endtask

  task automatic run_vector(input string tag, input bit dp, input bit toggle_dp,
                            input int max_gap, input int hold, input bit early);
    logic [63:0] emin, emax;
    logic [CW-1:0] ecnt;
    logic einv, eall;
    bit d;
    model(dp, emin, emax, ecnt, einv, eall);
    out_ready = 0;
    foreach (vec[i]) begin
      d = (i == 0) ? dp : (toggle_dp ? ~dp : 1'($urandom_range(0, 1)));
      if (i == vec.size() - 1 && early) out_ready = 1;
      send(vec[i], i == vec.size() - 1, d);
      if (i != vec.size() - 1)
        repeat ($urandom_range(0, max_gap)) begin
          in_data = {$urandom, $urandom};
          in_last = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
    end
    in_last = 0;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".min"}, out_min, emin);
    chk({tag, ".max"}, out_max, emax);
    chk({tag, ".count"}, 64'(out_count), 64'(ecnt));
    chk({tag, ".invalid"}, 64'(out_invalid), 64'(einv));
    chk({tag, ".all_nan"}, 64'(out_all_nan), 64'(eall));
    if (!early) begin
      for (int c = 0; c < hold; c++) begin
        in_valid = 1; in_data = {$urandom, $urandom};
        @(posedge clk); #1;
        chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".hold_min"}, out_min, emin);
        chk({tag, ".hold_max"}, out_max, emax);
        chk({tag, ".hold_count"}, 64'(out_count), 64'(ecnt));
      end
      in_valid = 0;
      out_ready = 1;
    end
    @(posedge clk); #1;
    chk({tag, ".idle_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle_count"}, 64'(out_count), 64'd0);
    chk({tag, ".idle_invalid"}, 64'(out_invalid), 64'd0);
    out_ready = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".min"}, out_min, 64'd0);
    chk({tag, ".max"}, out_max, 64'd0);
    chk({tag, ".count"}, 64'(out_count), 64'd0);
    chk({tag, ".invalid"}, 64'(out_invalid), 64'd0);
    chk({tag, ".all_nan"}, 64'(out_all_nan), 64'd0);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    vec = {64'h3F800000, 64'hC0000000, 64'h40600000};
    run_vector("sp_basic", 0, 0, 0, 0, 0);
    chk("sp_basic.result_min_const", out_min, 64'h0000_0000_C000_0000);

    vec = {64'h00000000, 64'h80000000};
    run_vector("sp_zeros", 0, 0, 1, 0, 1);

    vec = {64'h7FC00000, 64'h7F800001, 64'h3F800000};
    run_vector("sp_nan_mix", 0, 0, 0, 0, 0);

    vec = {64'h7F800001};
    run_vector("sp_single_snan", 0, 0, 0, 0, 0);

    vec = {64'hBFF0000000000000, 64'h7FF0000000000000, 64'h3FF0000000000000};
    run_vector("dp_toggle", 1, 1, 0, 0, 0);

    vec = {64'h3F800000, 64'h40000000, 64'hBF800000};
    run_vector("backpressure", 0, 0, 0, 5, 0);
    vec = {64'h00000001, 64'h00000002};
    run_vector("after_bp", 0, 0, 0, 0, 1);

    vec = {};
    for (int i = 0; i < 20; i++) vec.push_back(rand_fp(1'b0));
    run_vector("saturate", 0, 0, 0, 0, 0);

    // Reset in the middle of a vector.
    send(64'h3F800000, 0, 0);
    send(64'hC0000000, 0, 0);
    rst_n = 0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    vec = {64'h40600000};
    run_vector("post_reset", 0, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      bit dp;
      int len;
      dp  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 18);
      vec = {};
      for (int i = 0; i < len; i++) vec.push_back(rand_fp(dp));
      run_vector($sformatf("rand%0d", t), dp, 0, 2, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
